ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Prefetching instruction queue between the instruction memory port and the Fetch stage of the pipelined RV32 core. Keeps a program counter, issues sequential word fetches over a valid/ready request channel, accepts in-order responses and buffers instruction/PC pairs for in-order consumption by the Fetch stage. Execute-stage branch/jump redirects flush the queue, discard in-flight responses and restart fetch at the target.

## Interface
- ADDR_WIDTH, 32, address and PC width
- DAT_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2; also the cap on entries plus outstanding requests
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- redirect_i  input  1  taken branch/jump from Execute (PCSrc_E)
- redirect_pc_i  input  ADDR_WIDTH  redirect target (PCTarget_E)
- imem_req_valid_o  output  1  fetch request valid
- imem_req_addr_o  output  ADDR_WIDTH  fetch address, word aligned
- imem_req_ready_i  input  1  memory accepts request this cycle
- imem_rsp_valid_i  input  1  in-order response valid, always accepted
- imem_rsp_data_i  input  DAT_WIDTH  fetched instruction
- deq_valid_o  output  1  head entry valid
- deq_ready_i  input  1  Fetch stage consumes head (PC_Write)
- deq_ins_o  output  DAT_WIDTH  head instruction
- deq_pc_o  output  ADDR_WIDTH  head PC
- deq_pc4_o  output  ADDR_WIDTH  head PC + 4

## Operation
- State: fetch_pc, per-entry PC FIFO of issued requests, data FIFO (count 0..DEPTH), outstanding counter, kill counter (both width $clog2(DEPTH+1)).
- Issue: imem_req_valid_o = !redirect_i && (count + outstanding < DEPTH); imem_req_addr_o = fetch_pc. On valid&ready: fetch_pc += 4 (modulo 2^ADDR_WIDTH), outstanding++ , PC recorded in issue order.
- Response: if kill > 0, response dropped and kill--, outstanding--; else {data, issued PC} written at tail, outstanding--.
- Dequeue: deq_valid_o = count != 0; outputs are head entry combinationally; head advances on valid&ready.
- Redirect (redirect_i=1): fetch_pc ← redirect_pc_i; count ← 0; pointers cleared; kill ← outstanding minus any response arriving this cycle (that response is dropped); no request issued this cycle; dequeue in same cycle ignored.
- Credit rule guarantees no overflow: every accepted request owns a slot. Response with outstanding = 0 is a protocol error; flagged by assertion, ignored.
- Reset: fetch_pc = RESET_PC; count, outstanding, kill = 0; imem_req_valid_o = 1 in first cycle after reset release; deq_valid_o = 0; deq_ins_o, deq_pc_o = 0; deq_pc4_o = 4. Reset mid-transaction abandons all in-flight state; memory responses after reset with outstanding = 0 ignored.

## Timing
- Request-to-response latency ≥1 cycle, in order.
- Response written on edge N appears on deq_valid_o from cycle N+1 (no bypass).
- Minimum redirect-to-deq_valid: 3 cycles (redirect cycle 0, request cycle 1, response cycle 2, deq cycle 3).
- Simultaneous deq and response when full-of-credits: both occur; count unchanged.
- Sustained throughput one instruction/cycle with 1-cycle memory and DEPTH ≥ 2.

## Structure
- Package rv_fetch_pkg: fetch_entry_t struct {ins, pc}; INSN_BYTES = 4.
- One sub-module: fetch_fifo (parameterised sync FIFO of fetch_entry_t with flush input); queue control and PC logic in ifetch_queue.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr as data, deq_ready=1 -> deq_pc sequence 0x0,0x4,0x8..., one per cycle from cycle 3, deq_pc4 = pc+4.
- deq_ready=0 for 20 cycles -> exactly 4 requests issued, count=4, imem_req_valid_o=0; release -> 4 entries drained in order 0x0..0xC.
- Memory latency 3, redirect to 0x100 with 2 outstanding -> next 2 responses dropped, first deq_pc = 0x100, no stale instruction visible.
- Redirect coinciding with a response and deq_ready=1 -> response dropped, kill = outstanding-1, deq_valid_o=0 next cycle.
- imem_req_ready_i toggling 1/0 randomly -> PCs strictly +4, no duplicates or gaps, address held stable while valid&!ready.
- rst_n asserted mid-burst with 3 outstanding -> outputs at reset values immediately, first request after release to RESET_PC.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction prefetch queue
package rv_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with single-cycle flush, head visible combinationally
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_valid,
  input  entry_t        wr_data,
  input  logic          rd_ready,
  output logic          rd_valid,
  output entry_t        rd_data,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rd_fire;

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign rd_fire  = rd_ready && rd_valid;

  // Storage is cleared on reset so the head reads as zero before the first write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_valid) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_valid) - CW'(rd_fire);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - prefetching instruction queue between instruction memory and Fetch
module ifetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DAT_WIDTH  = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_req_ready_i,
  input  logic                  imem_rsp_valid_i,
  input  logic [DAT_WIDTH-1:0]  imem_rsp_data_i,
  output logic                  deq_valid_o,
  input  logic                  deq_ready_i,
  output logic [DAT_WIDTH-1:0]  deq_ins_o,
  output logic [ADDR_WIDTH-1:0] deq_pc_o,
  output logic [ADDR_WIDTH-1:0] deq_pc4_o
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [DAT_WIDTH-1:0]  ins;
    logic [ADDR_WIDTH-1:0] pc;
  } q_entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         kill;
  logic [CW-1:0]         count;
  logic [CW-1:0]         pc_count;
  logic                  pc_valid;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic                  credit_ok;
  logic                  issue;
  logic                  rsp_ok;
  logic                  rsp_live;
  q_entry_t              wr_entry;
  q_entry_t              head;

  // Every accepted request reserves a queue slot, so responses can never overflow
  assign credit_ok        = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_W;
  assign imem_req_valid_o = !redirect_i && credit_ok;
  assign imem_req_addr_o  = fetch_pc;
  assign issue            = imem_req_valid_o && imem_req_ready_i;

  assign rsp_ok   = imem_rsp_valid_i && (outstanding != '0);
  assign rsp_live = rsp_ok && (kill == '0) && !redirect_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
    end else if (redirect_i) begin
      // Everything still in flight belongs to the wrong path; a response landing now is dropped too
      fetch_pc    <= redirect_pc_i;
      outstanding <= outstanding - CW'(rsp_ok);
      kill        <= outstanding - CW'(rsp_ok);
    end else begin
      if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(INSN_BYTES);
      outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
      if (rsp_ok && (kill != '0)) kill <= kill - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (logic [ADDR_WIDTH-1:0])
  ) u_pc_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_i),
    .wr_valid (issue),
    .wr_data  (fetch_pc),
    .rd_ready (rsp_live),
    .rd_valid (pc_valid),
    .rd_data  (rsp_pc),
    .count    (pc_count)
  );

  assign wr_entry = '{ins: imem_rsp_data_i, pc: rsp_pc};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (q_entry_t)
  ) u_data_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_i),
    .wr_valid (rsp_live),
    .wr_data  (wr_entry),
    .rd_ready (deq_ready_i && !redirect_i),
    .rd_valid (deq_valid_o),
    .rd_data  (head),
    .count    (count)
  );

  assign deq_ins_o = head.ins;
  assign deq_pc_o  = head.pc;
  assign deq_pc4_o = head.pc + ADDR_WIDTH'(INSN_BYTES);

  a_rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid_i |-> (outstanding != '0));
  a_live_rsp_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_live |-> pc_valid);
  a_pc_fifo_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    pc_count == (outstanding - kill));

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed bench for ifetch_queue with an in-order memory model
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [31:0] deq_ins_o;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_pc4_o;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .deq_valid_o      (deq_valid_o),
    .deq_ready_i      (deq_ready_i),
    .deq_ins_o        (deq_ins_o),
    .deq_pc_o         (deq_pc_o),
    .deq_pc4_o        (deq_pc4_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq [$];
  logic [31:0] req_log [$];
  logic [31:0] deq_log [$];
  logic [31:0] deq_cyc [$];

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          cyc;
  int          lat;
  int          hold_err = 0;
  int          data_err = 0;
  bit          release_pending;
  bit          rdy_rand;
  bit          deq_rand;
  bit          tb_redirect;
  logic [31:0] tb_redirect_pc;
  bit          tb_deq_ready;
  bit          hold_pending;
  logic [31:0] hold_addr;
  logic        last_req_valid;
  logic [31:0] last_req_addr;
  logic        last_deq_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    deq_ready_i      = 1'b0;
    tb_redirect      = 1'b0;
    rdy_rand         = 1'b0;
    deq_rand         = 1'b0;
    hold_pending     = 1'b0;
    mq.delete();
    req_log.delete();
    deq_log.delete();
    deq_cyc.delete();
    cyc = 0;
    repeat (2) @(negedge clk);
    #1;
    release_pending = 1'b1;
  endtask

  // One clock: drive inputs just after the falling edge, sample outputs 1 time unit later
  task automatic cycle();
    @(negedge clk);
    if (release_pending) begin
      rst_n           = 1'b1;
      release_pending = 1'b0;
    end
    cyc++;
    redirect_i       = tb_redirect;
    redirect_pc_i    = tb_redirect_pc;
    deq_ready_i      = deq_rand ? 1'($urandom_range(0, 1)) : tb_deq_ready;
    imem_req_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mq[0].addr;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    last_req_valid = imem_req_valid_o;
    last_req_addr  = imem_req_addr_o;
    last_deq_valid = deq_valid_o;
    if (hold_pending && imem_req_valid_o && imem_req_addr_o !== hold_addr) hold_err++;
    hold_pending = imem_req_valid_o && !imem_req_ready_i;
    hold_addr    = imem_req_addr_o;
    if (imem_req_valid_o && imem_req_ready_i) begin
      mq.push_back('{imem_req_addr_o, cyc + lat});
      req_log.push_back(imem_req_addr_o);
    end
    if (deq_valid_o && deq_ready_i && !redirect_i) begin
      deq_log.push_back(deq_pc_o);
      deq_cyc.push_back(32'(cyc));
      if (deq_ins_o !== deq_pc_o || deq_pc4_o !== deq_pc_o + 32'd4) data_err++;
    end
  endtask

  initial begin
    int bad;
    rst_n            = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    deq_ready_i      = 1'b0;
    tb_redirect_pc   = '0;
    tb_deq_ready     = 1'b0;
    lat              = 1;

    // Reset values, then streaming with a 1-cycle memory
    do_reset();
    check("rst_deq_valid", 32'(deq_valid_o), 32'd0);
    check("rst_deq_ins", deq_ins_o, 32'h0);
    check("rst_deq_pc", deq_pc_o, 32'h0);
    check("rst_deq_pc4", deq_pc4_o, 32'h4);
    lat = 1; tb_deq_ready = 1'b1;
    cycle();
    check("first_req_valid", 32'(last_req_valid), 32'd1);
    check("first_req_addr", last_req_addr, 32'h0);
    repeat (9) cycle();
    check("stream_len", deq_log.size(), 32'd8);
    check("stream_first_cyc", q_at(deq_cyc, 0), 32'd3);
    bad = 0;
    for (int i = 0; i < 8; i++) if (q_at(deq_log, i) !== 32'(4 * i)) bad++;
    check("stream_seq", bad, 32'd0);

    // Consumer stalled: credits cap requests at DEPTH
    do_reset();
    lat = 1; tb_deq_ready = 1'b0;
    repeat (20) cycle();
    check("fill_reqs", req_log.size(), 32'd4);
    check("fill_req_valid", 32'(last_req_valid), 32'd0);
    check("fill_deq_valid", 32'(last_deq_valid), 32'd1);
    tb_deq_ready = 1'b1;
    repeat (6) cycle();
    for (int i = 0; i < 4; i++) check($sformatf("drain_%0d", i), q_at(deq_log, i), 32'(4 * i));

    // Redirect with two responses in flight on a 3-cycle memory
    do_reset();
    lat = 3; tb_deq_ready = 1'b1;
    repeat (2) cycle();
    tb_redirect = 1'b1; tb_redirect_pc = 32'h100;
    cycle();
    check("redir_req_blocked", 32'(last_req_valid), 32'd0);
    tb_redirect = 1'b0;
    repeat (8) cycle();
    check("redir_req_addr", q_at(req_log, 2), 32'h100);
    check("redir_first_pc", q_at(deq_log, 0), 32'h100);
    check("redir_second_pc", q_at(deq_log, 1), 32'h104);
    check("redir_first_cyc", q_at(deq_cyc, 0), 32'd8);

    // Redirect in the same cycle as a response and a dequeue
    do_reset();
    lat = 1; tb_deq_ready = 1'b1;
    repeat (3) cycle();
    tb_redirect = 1'b1; tb_redirect_pc = 32'h200;
    cycle();
    tb_redirect = 1'b0;
    cycle();
    check("coinc_deq_valid", 32'(last_deq_valid), 32'd0);
    check("coinc_req_addr", last_req_addr, 32'h200);
    repeat (3) cycle();
    check("coinc_deq_count", deq_log.size(), 32'd3);
    check("coinc_pc", q_at(deq_log, 1), 32'h200);
    check("coinc_cyc", q_at(deq_cyc, 1), 32'd7);

    // Random request/dequeue backpressure
    do_reset();
    lat = 1; rdy_rand = 1'b1; deq_rand = 1'b1;
    repeat (300) cycle();
    rdy_rand = 1'b0; deq_rand = 1'b0; tb_deq_ready = 1'b1;
    repeat (10) cycle();
    bad = 0;
    foreach (req_log[i]) if (req_log[i] !== 32'(4 * i)) bad++;
    check("rand_req_seq", bad, 32'd0);
    bad = 0;
    foreach (deq_log[i]) if (deq_log[i] !== 32'(4 * i)) bad++;
    check("rand_deq_seq", bad, 32'd0);
    check("rand_progress", 32'(deq_log.size() >= 50), 32'd1);
    check("rand_addr_hold", hold_err, 32'd0);

    // Asynchronous reset with three requests outstanding
    do_reset();
    lat = 3; tb_deq_ready = 1'b0;
    repeat (4) cycle();
    @(negedge clk);
    #1;
    check("pre_rst_deq_valid", 32'(deq_valid_o), 32'd1);
    check("pre_rst_req_addr", imem_req_addr_o, 32'h10);
    rst_n = 1'b0;
    mq.delete();
    imem_rsp_valid_i = 1'b0;
    #1;
    check("async_rst_deq_valid", 32'(deq_valid_o), 32'd0);
    check("async_rst_deq_pc4", deq_pc4_o, 32'h4);
    check("async_rst_req_addr", imem_req_addr_o, 32'h0);
    do_reset();
    lat = 1; tb_deq_ready = 1'b1;
    cycle();
    check("post_rst_req_valid", 32'(last_req_valid), 32'd1);
    check("post_rst_req_addr", last_req_addr, 32'h0);
    repeat (4) cycle();
    check("post_rst_first_pc", q_at(deq_log, 0), 32'h0);
    check("post_rst_second_pc", q_at(deq_log, 1), 32'h4);

    check("deq_ins_pc4_consistent", data_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
